// File: rtl/input_filter_pkg.sv
// Shared constants for the multi-channel input filter.
//   FILT_CNT_W   : default integrator counter width
//   FILT_CNT_MAX : default counter saturation ceiling
//   FILT_TH_HI   : default count at or above which the clean level sets
//   FILT_TH_LO   : default count at or below which the clean level clears
//   SYNC_STAGES  : depth of the per-channel metastability synchroniser
//   filt_params_ok() : legality check used at elaboration time
package input_filter_pkg;

    localparam int FILT_CNT_W   = 8;
    localparam int FILT_CNT_MAX = 7;
    localparam int FILT_TH_HI   = 5;
    localparam int FILT_TH_LO   = 2;
    localparam int SYNC_STAGES  = 2;

    // The thresholds must leave a non-empty hysteresis band inside [0, CNT_MAX],
    // and the ceiling must fit in the counter.
    function automatic bit filt_params_ok(int cnt_w, int cnt_max, int th_hi, int th_lo);
        bit fits;
        fits = (cnt_w >= 1) && ((cnt_w >= 31) || (cnt_max < (1 << cnt_w)));
        return fits && (th_lo >= 0) && (th_lo < th_hi) && (th_hi <= cnt_max);
    endfunction

endpackage

// File: rtl/input_filter_ch.sv
// One filter channel: 2-flop synchroniser, saturating up/down integrator,
// hysteresis output register and registered rise/fall strobes.
// Ports:
//   Clk  : clock, rising edge
//   Rst  : asynchronous active-high reset
//   En   : integrator update enable (synchroniser always runs)
//   DIn  : raw asynchronous input
//   DOut : filtered level
//   Rise : one-cycle pulse coincident with DOut 0->1
//   Fall : one-cycle pulse coincident with DOut 1->0
module input_filter_ch
    import input_filter_pkg::*;
#(
    parameter int CNT_W   = FILT_CNT_W,
    parameter int CNT_MAX = FILT_CNT_MAX,
    parameter int TH_HI   = FILT_TH_HI,
    parameter int TH_LO   = FILT_TH_LO
) (
    input  logic Clk,
    input  logic Rst,
    input  logic En,
    input  logic DIn,
    output logic DOut,
    output logic Rise,
    output logic Fall
);

    localparam logic [CNT_W-1:0] CNT_MAX_C = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] TH_HI_C   = CNT_W'(TH_HI);
    localparam logic [CNT_W-1:0] TH_LO_C   = CNT_W'(TH_LO);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sample;
    logic [CNT_W-1:0]       count_reg;
    logic [CNT_W-1:0]       count_next;
    logic                   dout_reg;
    logic                   dout_next;
    logic                   rise_reg;
    logic                   fall_reg;

    // Only the last synchroniser stage is allowed to influence the integrator.
    assign sample = sync_reg[SYNC_STAGES-1];

    always_comb begin
        count_next = count_reg;
        dout_next  = dout_reg;
        if (En) begin
            if (sample && (count_reg < CNT_MAX_C)) begin
                count_next = count_reg + ONE_C;
            end else if (!sample && (count_reg != '0)) begin
                count_next = count_reg - ONE_C;
            end
            // Thresholds are judged on the new count so the output moves on
            // the same edge the count crosses them.
            if (count_next >= TH_HI_C) begin
                dout_next = 1'b1;
            end else if (count_next <= TH_LO_C) begin
                dout_next = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            sync_reg  <= '0;
            count_reg <= '0;
            dout_reg  <= 1'b0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[SYNC_STAGES-2:0], DIn};
            count_reg <= count_next;
            dout_reg  <= dout_next;
            // dout_next equals dout_reg whenever En is low, so no strobe then.
            rise_reg  <= dout_next & ~dout_reg;
            fall_reg  <= ~dout_next & dout_reg;
        end
    end

    assign DOut = dout_reg;
    assign Rise = rise_reg;
    assign Fall = fall_reg;

endmodule

// File: rtl/input_filter_mc.sv
// Multi-channel debounce/glitch filter: CH independent input_filter_ch
// instances sharing clock, reset and enable.
// Ports:
//   Clk  : clock, rising edge
//   Rst  : asynchronous active-high reset
//   En   : integrator update enable for all channels
//   DIn  : [CH-1:0] raw asynchronous inputs
//   DOut : [CH-1:0] filtered levels
//   Rise : [CH-1:0] one-cycle rising strobes
//   Fall : [CH-1:0] one-cycle falling strobes
module input_filter_mc
    import input_filter_pkg::*;
#(
    parameter int CH      = 4,
    parameter int CNT_W   = FILT_CNT_W,
    parameter int CNT_MAX = FILT_CNT_MAX,
    parameter int TH_HI   = FILT_TH_HI,
    parameter int TH_LO   = FILT_TH_LO
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          En,
    input  logic [CH-1:0] DIn,
    output logic [CH-1:0] DOut,
    output logic [CH-1:0] Rise,
    output logic [CH-1:0] Fall
);

    if (CH < 1) begin : g_bad_ch
        $error("input_filter_mc: CH must be at least 1");
    end

    if (!filt_params_ok(CNT_W, CNT_MAX, TH_HI, TH_LO)) begin : g_bad_params
        $error("input_filter_mc: need 0 <= TH_LO < TH_HI <= CNT_MAX < 2**CNT_W");
    end

    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
        input_filter_ch #(
            .CNT_W   (CNT_W),
            .CNT_MAX (CNT_MAX),
            .TH_HI   (TH_HI),
            .TH_LO   (TH_LO)
        ) u_ch (
            .Clk  (Clk),
            .Rst  (Rst),
            .En   (En),
            .DIn  (DIn[gi]),
            .DOut (DOut[gi]),
            .Rise (Rise[gi]),
            .Fall (Fall[gi])
        );
    end

endmodule

// File: tb/tb_input_filter_mc.sv
module tb_input_filter_mc;

    localparam int CH      = 4;
    localparam int CNT_MAX = 7;
    localparam int TH_HI   = 5;
    localparam int TH_LO   = 2;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          En;
    logic [CH-1:0] DIn;
    logic [CH-1:0] DOut;
    logic [CH-1:0] Rise;
    logic [CH-1:0] Fall;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: per-channel input delay line, integer level and clean state.
    int            m_cnt [CH];
    logic [CH-1:0] m_s1, m_s2, m_dout, m_rise, m_fall;

    input_filter_mc #(
        .CH      (CH),
        .CNT_W   (8),
        .CNT_MAX (CNT_MAX),
        .TH_HI   (TH_HI),
        .TH_LO   (TH_LO)
    ) dut (
        .Clk  (Clk),
        .Rst  (Rst),
        .En   (En),
        .DIn  (DIn),
        .DOut (DOut),
        .Rise (Rise),
        .Fall (Fall)
    );

    always #5 Clk = ~Clk;

    task automatic model_reset();
        for (int i = 0; i < CH; i++) m_cnt[i] = 0;
        m_s1 = '0; m_s2 = '0; m_dout = '0; m_rise = '0; m_fall = '0;
    endtask

    // Advance one clock edge; the model sees the inputs as they were before the edge.
    task automatic tick();
        logic nd;
        @(posedge Clk);
        if (Rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < CH; i++) begin
                m_rise[i] = 1'b0;
                m_fall[i] = 1'b0;
                if (En) begin
                    if (m_s2[i]) m_cnt[i] = (m_cnt[i] + 1 > CNT_MAX) ? CNT_MAX : m_cnt[i] + 1;
                    else         m_cnt[i] = (m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1;
                    nd = m_dout[i];
                    if (m_cnt[i] >= TH_HI) nd = 1'b1;
                    else if (m_cnt[i] <= TH_LO) nd = 1'b0;
                    m_rise[i] = nd && !m_dout[i];
                    m_fall[i] = !nd && m_dout[i];
                    m_dout[i] = nd;
                end
            end
            m_s2 = m_s1;
            m_s1 = DIn;
        end
        #1;
    endtask

    task automatic test_reset();
        int rise_edge;
        Rst = 1'b1; En = 1'b1; DIn = '0;
        model_reset();
        #12;
        compared++;
        if ({DOut, Rise, Fall} !== 12'h000) begin
            mismatched++;
            $display("FAIL reset_state got=%h exp=000", {DOut, Rise, Fall});
        end
        @(negedge Clk); Rst = 1'b0;
        // Ramp to count 4 (DOut still 0), then reset between edges.
        DIn = '1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            compared++;
            if ({DOut, Rise, Fall} !== {m_dout, m_rise, m_fall}) begin
                mismatched++;
                $display("FAIL reset_ramp e=%0d got=%h exp=%h", e, {DOut, Rise, Fall}, {m_dout, m_rise, m_fall});
            end
        end
        #3; Rst = 1'b1; model_reset(); #1;
        compared++;
        if ({DOut, Rise, Fall} !== 12'h000) begin
            mismatched++;
            $display("FAIL reset_midcount got=%h exp=000", {DOut, Rise, Fall});
        end
        // Reset also has to knock down an asserted level without a clock edge.
        @(negedge Clk); Rst = 1'b0;
        for (int e = 1; e <= 10; e++) tick();
        compared++;
        if (DOut !== 4'hF) begin
            mismatched++;
            $display("FAIL reset_prehigh got=%h exp=f", DOut);
        end
        #2; Rst = 1'b1; model_reset(); #1;
        compared++;
        if ({DOut, Rise, Fall} !== 12'h000) begin
            mismatched++;
            $display("FAIL reset_async_high got=%h exp=000", {DOut, Rise, Fall});
        end
        @(negedge Clk); Rst = 1'b0;
        rise_edge = -1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            compared++;
            if ({DOut, Rise, Fall} !== {m_dout, m_rise, m_fall}) begin
                mismatched++;
                $display("FAIL reset_release e=%0d got=%h exp=%h", e, {DOut, Rise, Fall}, {m_dout, m_rise, m_fall});
            end
            if (Rise[0] && rise_edge < 0) rise_edge = e;
        end
        compared++;
        if (rise_edge != TH_HI + 2) begin
            mismatched++;
            $display("FAIL reset_rise_latency got=%0d exp=%0d", rise_edge, TH_HI + 2);
        end
        $display("test_reset done: rise edge after release %0d", rise_edge);
    endtask

    task automatic test_glitch();
        int rise_edge, rises;
        DIn = '0;
        for (int e = 0; e < 12; e++) tick();
        rises = 0;
        DIn[0] = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            compared++;
            if ({DOut, Rise, Fall} !== {m_dout, m_rise, m_fall}) begin
                mismatched++;
                $display("FAIL glitch4 e=%0d got=%h exp=%h", e, {DOut, Rise, Fall}, {m_dout, m_rise, m_fall});
            end
            if (Rise[0] || DOut[0]) rises++;
            if (e == 4) DIn[0] = 1'b0;
        end
        compared++;
        if (rises != 0) begin
            mismatched++;
            $display("FAIL glitch4_reject got=%0d exp=0", rises);
        end
        rise_edge = -1;
        DIn[0] = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            compared++;
            if ({DOut, Rise, Fall} !== {m_dout, m_rise, m_fall}) begin
                mismatched++;
                $display("FAIL glitch5 e=%0d got=%h exp=%h", e, {DOut, Rise, Fall}, {m_dout, m_rise, m_fall});
            end
            if (Rise[0] && rise_edge < 0) rise_edge = e;
            if (e == 5) DIn[0] = 1'b0;
        end
        compared++;
        if (rise_edge != 7) begin
            mismatched++;
            $display("FAIL glitch5_rise got=%0d exp=7", rise_edge);
        end
        $display("test_glitch done: 4-cycle hits %0d, 5-cycle rise edge %0d", rises, rise_edge);
    endtask

    task automatic test_hysteresis();
        DIn = '1;
        for (int e = 0; e < 15; e++) tick();
        for (int e = 1; e <= 40; e++) begin
            DIn = ~DIn;
            tick();
            compared++;
            if ({DOut, Rise, Fall} !== {m_dout, m_rise, m_fall} || DOut !== 4'hF || Fall !== 4'h0) begin
                mismatched++;
                $display("FAIL hysteresis e=%0d got=%h exp=%h", e, {DOut, Rise, Fall}, {m_dout, m_rise, m_fall});
            end
        end
        $display("test_hysteresis done: DOut=%h", DOut);
    endtask

    task automatic test_saturation();
        int rises, falls;
        DIn = '0;
        for (int e = 0; e < 20; e++) tick();
        rises = 0; falls = 0;
        for (int e = 1; e <= 100; e++) begin
            DIn = (e <= 50) ? '1 : '0;
            tick();
            compared++;
            if ({DOut, Rise, Fall} !== {m_dout, m_rise, m_fall}) begin
                mismatched++;
                $display("FAIL saturation e=%0d got=%h exp=%h", e, {DOut, Rise, Fall}, {m_dout, m_rise, m_fall});
            end
            if (Rise[2]) rises++;
            if (Fall[2]) falls++;
        end
        for (int e = 0; e < 10; e++) tick();
        compared++;
        if (rises != 1 || falls != 1 || DOut !== 4'h0) begin
            mismatched++;
            $display("FAIL saturation_edges got rise=%0d fall=%0d dout=%h exp rise=1 fall=1 dout=0", rises, falls, DOut);
        end
        $display("test_saturation done: rises=%0d falls=%0d", rises, falls);
    endtask

    task automatic test_en_freeze();
        int rise_edge;
        DIn = '0; En = 1'b1;
        for (int e = 0; e < 12; e++) tick();
        DIn = '1;
        for (int e = 0; e < 5; e++) tick();   // count reaches 3
        En = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            compared++;
            if ({DOut, Rise, Fall} !== {m_dout, m_rise, m_fall} || DOut !== 4'h0 || Rise !== 4'h0) begin
                mismatched++;
                $display("FAIL en_freeze e=%0d got=%h exp=%h", e, {DOut, Rise, Fall}, {m_dout, m_rise, m_fall});
            end
        end
        En = 1'b1;
        rise_edge = -1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            compared++;
            if ({DOut, Rise, Fall} !== {m_dout, m_rise, m_fall}) begin
                mismatched++;
                $display("FAIL en_resume e=%0d got=%h exp=%h", e, {DOut, Rise, Fall}, {m_dout, m_rise, m_fall});
            end
            if (Rise[1] && rise_edge < 0) rise_edge = e;
        end
        compared++;
        if (rise_edge != 2) begin
            mismatched++;
            $display("FAIL en_resume_rise got=%0d exp=2", rise_edge);
        end
        $display("test_en_freeze done: rise %0d edges after enable", rise_edge);
    endtask

    task automatic test_independence();
        int rise0, fall3;
        int hold [CH];
        DIn = 4'b1000; En = 1'b1;
        for (int e = 0; e < 15; e++) tick();
        // ch0 rises from 0 while ch3 falls from saturation: both land on edge 7.
        DIn = 4'b0001;
        rise0 = -1; fall3 = -1;
        for (int e = 1; e <= 12; e++) begin
            DIn[2:1] = 2'($urandom_range(0, 3));
            tick();
            compared++;
            if ({DOut, Rise, Fall} !== {m_dout, m_rise, m_fall}) begin
                mismatched++;
                $display("FAIL indep_edge e=%0d got=%h exp=%h", e, {DOut, Rise, Fall}, {m_dout, m_rise, m_fall});
            end
            if (Rise[0] && rise0 < 0) rise0 = e;
            if (Fall[3] && fall3 < 0) fall3 = e;
        end
        compared++;
        if (rise0 != 7 || fall3 != 7) begin
            mismatched++;
            $display("FAIL indep_simul got rise0=%0d fall3=%0d exp 7/7", rise0, fall3);
        end
        // Staggered random runs per channel with occasional enable drops.
        for (int i = 0; i < CH; i++) hold[i] = 0;
        for (int e = 1; e <= 600; e++) begin
            for (int i = 0; i < CH; i++) begin
                if (hold[i] == 0) begin
                    DIn[i]  = ~DIn[i];
                    hold[i] = int'($urandom_range(1, 10));
                end
                hold[i]--;
            end
            En = ($urandom_range(0, 9) != 0);
            tick();
            compared++;
            if ({DOut, Rise, Fall} !== {m_dout, m_rise, m_fall}) begin
                mismatched++;
                $display("FAIL indep_random e=%0d got=%h exp=%h", e, {DOut, Rise, Fall}, {m_dout, m_rise, m_fall});
            end
        end
        En = 1'b1;
        $display("test_independence done: simultaneous edges at %0d/%0d", rise0, fall3);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_glitch();
        test_hysteresis();
        test_saturation();
        test_en_freeze();
        test_independence();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
